irda_frame_tx: RTL and testbench



---
 rtl/irda_pkg.sv | 22 ++
 rtl/irda_frame_tx_bit_timer.sv | 35 +++
 rtl/irda_frame_tx.sv | 102 ++++++++++
 tb/tb_irda_frame_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/irda_pkg.sv
// Shared IrDA framing constants, transmitter state encoding and parity helper.
package irda_pkg;

    localparam int unsigned DATA_BITS  = 7;
    localparam int unsigned FRAME_BITS = 10;
    localparam logic        START_BIT  = 1'b0;
    localparam logic        STOP_BIT   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Odd parity: XOR of data bits and the returned bit is 1.
    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/irda_frame_tx_bit_timer.sv
// Bit-period timer; pulse_window and bit_end_next describe the count of the
// following cycle so the caller can register outputs aligned with it.
module irda_bit_timer #(
    parameter int unsigned CLKS_PER_BIT    = 16,
    parameter int unsigned IRDA_PULSE_CLKS = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_end,
    output logic bit_end_next,
    output logic pulse_window
);

    localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    always_comb begin
        bit_end      = run && (count == CW'(CLKS_PER_BIT - 1));
        count_next   = (!run || bit_end) ? '0 : count + CW'(1);
        bit_end_next = (count_next == CW'(CLKS_PER_BIT - 1));
        pulse_window = (count_next < CW'(IRDA_PULSE_CLKS));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/irda_frame_tx.sv
// IrDA transmit framer: start, 7 data bits LSB-first, odd parity, stop,
// driven as NRZ on txd and as RZI pulses on ir_tx.
module irda_frame_tx
    import irda_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT    = 16,
    parameter int unsigned IRDA_PULSE_CLKS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 ir_tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned SHIFT_W = FRAME_BITS - 1;
    localparam int unsigned IDX_W   = $clog2(DATA_BITS);

    if (CLKS_PER_BIT < 2 || IRDA_PULSE_CLKS < 1 || IRDA_PULSE_CLKS >= CLKS_PER_BIT) begin : g_param_check
        $error("irda_frame_tx: illegal CLKS_PER_BIT / IRDA_PULSE_CLKS combination");
    end

    tx_state_t          state;
    logic [SHIFT_W-1:0] shift;
    logic [IDX_W-1:0]   bit_idx;
    logic               bit_end;
    logic               bit_end_next;
    logic               pulse_window;

    assign tx_ready = (state == IDLE);

    irda_bit_timer #(
        .CLKS_PER_BIT    (CLKS_PER_BIT),
        .IRDA_PULSE_CLKS (IRDA_PULSE_CLKS)
    ) u_bit_timer (
        .clk          (clk),
        .rst          (rst),
        .run          (state != IDLE),
        .bit_end      (bit_end),
        .bit_end_next (bit_end_next),
        .pulse_window (pulse_window)
    );

    // Registered outputs are loaded with the value of the upcoming cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift      <= '0;
            bit_idx    <= '0;
            txd        <= STOP_BIT;
            ir_tx      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == STOP) && bit_end_next;
            case (state)
                IDLE: begin
                    txd   <= STOP_BIT;
                    ir_tx <= 1'b0;
                    if (tx_valid) begin
                        shift   <= {STOP_BIT, odd_parity(tx_data), tx_data};
                        bit_idx <= '0;
                        state   <= START;
                        busy    <= 1'b1;
                        txd     <= START_BIT;
                        ir_tx   <= pulse_window;
                    end
                end
                default: begin
                    if (bit_end) begin
                        txd   <= shift[0];
                        ir_tx <= ~shift[0] & pulse_window;
                        shift <= {STOP_BIT, shift[SHIFT_W-1:1]};
                        case (state)
                            START: state <= DATA;
                            DATA: begin
                                bit_idx <= bit_idx + IDX_W'(1);
                                if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                                    state <= PARITY;
                                end
                            end
                            PARITY: state <= STOP;
                            default: begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                txd   <= STOP_BIT;
                                ir_tx <= 1'b0;
                            end
                        endcase
                    end else begin
                        ir_tx <= ~txd & pulse_window;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irda_frame_tx.sv
// Scoreboard bench for irda_frame_tx at 16/3 and 4/1 clock/pulse settings.
module tb_irda_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst;
    logic [1:0] tx_valid;
    logic [6:0] tx_data [2];
    wire  [1:0] tx_ready;
    wire  [1:0] txd;
    wire  [1:0] ir_tx;
    wire  [1:0] busy;
    wire  [1:0] frame_done;

    int errors = 0;
    int checks = 0;
    int frames [2];
    int gap_len [2];
    int fd_cnt [2];
    logic [9:0] q0 [$];
    logic [9:0] q1 [$];

    irda_frame_tx #(.CLKS_PER_BIT(16), .IRDA_PULSE_CLKS(3)) dut0 (
        .clk(clk), .rst(rst[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .txd(txd[0]), .ir_tx(ir_tx[0]), .busy(busy[0]),
        .frame_done(frame_done[0])
    );

    irda_frame_tx #(.CLKS_PER_BIT(4), .IRDA_PULSE_CLKS(1)) dut1 (
        .clk(clk), .rst(rst[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .txd(txd[1]), .ir_tx(ir_tx[1]), .busy(busy[1]),
        .frame_done(frame_done[1])
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int qsize(input int id);
        return (id == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(input int id, input logic [9:0] f);
        if (id == 0) q0.push_back(f);
        else         q1.push_back(f);
    endtask

    task automatic pop(input int id, output logic [9:0] f);
        if (id == 0) f = q0.pop_front();
        else         f = q1.pop_front();
    endtask

    always @(negedge clk) begin
        if (frame_done[0]) fd_cnt[0]++;
        if (frame_done[1]) fd_cnt[1]++;
    end

    // Monitor: on each frame start pop the expected frame and compare every clock.
    task automatic monitor(input int id, input int cpb, input int pw);
        int         idle_run = 0;
        int         bad;
        bit         aborted;
        logic [9:0] f;
        forever begin
            @(negedge clk);
            if (rst[id]) begin
                idle_run = 0;
            end else if (txd[id]) begin
                idle_run++;
            end else begin
                gap_len[id] = idle_run;
                idle_run    = 0;
                frames[id]++;
                check($sformatf("dut%0d frame%0d expected", id, frames[id]), int'(qsize(id) > 0), 1);
                if (qsize(id) == 0) begin
                    for (int n = 0; n < 20 * cpb && busy[id]; n++) @(negedge clk);
                end else begin
                    pop(id, f);
                    aborted = 1'b0;
                    for (int b = 0; b < 10 && !aborted; b++) begin
                        bad = 0;
                        for (int p = 0; p < cpb; p++) begin
                            if (b != 0 || p != 0) @(negedge clk);
                            if (rst[id]) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (txd[id] !== f[b]) bad++;
                            if (ir_tx[id] !== (!f[b] && p < pw)) bad++;
                            if (frame_done[id] !== (b == 9 && p == cpb - 1)) bad++;
                            if (busy[id] !== 1'b1 || tx_ready[id] !== 1'b0) bad++;
                        end
                        if (!aborted)
                            check($sformatf("dut%0d frame%0d bit%0d bad clocks", id, frames[id], b), bad, 0);
                    end
                end
            end
        end
    endtask

    initial monitor(0, 16, 3);
    initial monitor(1, 4, 1);

    task automatic send(input int id, input logic [6:0] d, input logic [9:0] f, input bit hold);
        int n = 0;
        @(negedge clk);
        while (!tx_ready[id] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready[id]) begin
            check($sformatf("dut%0d ready wait", id), int'(tx_ready[id]), 1);
            return;
        end
        tx_data[id]  = d;
        tx_valid[id] = 1'b1;
        push(id, f);
        @(posedge clk);
        #1;
        if (!hold) tx_valid[id] = 1'b0;
    endtask

    task automatic wait_idle(input int id);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy[id] || !tx_ready[id]) && n < 5000);
        if (busy[id]) check($sformatf("dut%0d idle wait", id), int'(busy[id]), 0);
        @(negedge clk);
    endtask

    task automatic churn(input int id, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            tx_valid[id] = 1'($urandom_range(0, 1));
            tx_data[id]  = 7'($urandom);
        end
        tx_valid[id] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 2'b11;
        tx_valid   = 2'b00;
        tx_data[0] = 7'h00;
        tx_data[1] = 7'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset txd", int'(txd[0]), 1);
        check("reset ir_tx", int'(ir_tx[0]), 0);
        check("reset busy", int'(busy[0]), 0);
        check("reset frame_done", int'(frame_done[0]), 0);
        check("reset tx_ready", int'(tx_ready[0]), 1);
        check("reset dut1 txd", int'(txd[1]), 1);
        rst = 2'b00;

        // Reference frame and parity corners
        send(0, 7'h55, 10'b1_1_1010101_0, 1'b0);
        send(0, 7'h00, 10'b1_1_0000000_0, 1'b0);
        send(0, 7'h7F, 10'b1_0_1111111_0, 1'b0);
        send(0, 7'h01, 10'b1_0_0000001_0, 1'b0);
        wait_idle(0);
        check("idle ir_tx", int'(ir_tx[0]), 0);
        check("idle txd", int'(txd[0]), 1);

        // Back-to-back with tx_valid held high
        send(0, 7'h12, 10'b1_1_0010010_0, 1'b1);
        gap_len[0] = -1;
        send(0, 7'h34, 10'b1_0_0110100_0, 1'b1);
        tx_valid[0] = 1'b0;
        @(negedge clk);
        #1;
        check("back-to-back idle gap", gap_len[0], 1);
        wait_idle(0);

        // Asynchronous reset in data bit 3, inside the IrDA pulse
        send(0, 7'h00, 10'b1_1_0000000_0, 1'b0);
        repeat (64) @(posedge clk);
        @(negedge clk);
        check("pre-reset txd", int'(txd[0]), 0);
        check("pre-reset ir_tx", int'(ir_tx[0]), 1);
        #1 rst[0] = 1'b1;
        #1;
        check("async reset txd", int'(txd[0]), 1);
        check("async reset ir_tx", int'(ir_tx[0]), 0);
        check("async reset busy", int'(busy[0]), 0);
        check("async reset tx_ready", int'(tx_ready[0]), 1);
        check("async reset frame_done", int'(frame_done[0]), 0);
        repeat (2) @(negedge clk);
        #1 rst[0] = 1'b0;
        send(0, 7'h2A, 10'b1_0_0101010_0, 1'b0);

        // Input churn while a frame is in flight
        send(0, 7'h55, 10'b1_1_1010101_0, 1'b0);
        churn(0, 7 * 16);
        wait_idle(0);

        send(1, 7'h55, 10'b1_1_1010101_0, 1'b0);
        churn(1, 7 * 4);
        wait_idle(1);
        send(1, 7'h00, 10'b1_1_0000000_0, 1'b0);
        send(1, 7'h7F, 10'b1_0_1111111_0, 1'b0);
        wait_idle(1);
        repeat (5) @(negedge clk);

        check("dut0 leftover expected frames", q0.size(), 0);
        check("dut1 leftover expected frames", q1.size(), 0);
        check("dut0 frames started", frames[0], 9);
        check("dut1 frames started", frames[1], 3);
        check("dut0 frame_done pulses", fd_cnt[0], 8);
        check("dut1 frame_done pulses", fd_cnt[1], 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
